// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier for the M-extension path (MUL/MULH/MULHSU/MULHU).
// Start/busy/done handshake with abort and a zero-operand early-out.
module seq_mul_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              res_hi_q, res_hi_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              a_neg_c, b_neg_c, zero_c;
    logic [WIDTH-1:0]  mag_a_c, mag_b_c;
    logic [PW-1:0]     acc_sum_c;

    // Operand magnitudes; the most-negative value maps onto itself, which is the correct unsigned magnitude
    always_comb begin
        a_neg_c   = (op == 2'b01 || op == 2'b10) && a[WIDTH-1];
        b_neg_c   = (op == 2'b01) && b[WIDTH-1];
        mag_a_c   = a_neg_c ? (~a + WIDTH'(1)) : a;
        mag_b_c   = b_neg_c ? (~b + WIDTH'(1)) : b;
        zero_c    = (a == '0) || (b == '0);
        acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            res_hi_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            res_hi_q <= res_hi_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; res_hi only changes together with the product so result stays stable on abort
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        res_hi_d = res_hi_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    op_d     = op;
                    neg_d    = a_neg_c ^ b_neg_c;
                    mcand_d  = {WIDTH'(0), mag_a_c};
                    mplier_d = mag_b_c;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (EARLY_ZERO && zero_c) begin
                        prod_d   = '0;
                        res_hi_d = (op != 2'b00);
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_sum_c;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        prod_d   = neg_q ? (~acc_sum_c + PW'(1)) : acc_sum_c;
                        res_hi_d = (op_q != 2'b00);
                        state_d  = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = prod_q;
    assign result  = res_hi_q ? prod_q[PW-1:WIDTH] : prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_mul_unit.sv
// Bench for seq_mul_unit (WIDTH=32): vector table plus handshake corner sequences,
// results checked through a scoreboard queue popped on every done pulse.
module tb_seq_mul_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [63:0] product;

    seq_mul_unit #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .result(result), .product(product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [63:0] prod;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [63:0] prod;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b);
        logic [63:0] sa, sbv;
        sa  = (m_op == 2'd1 || m_op == 2'd2) ? {{32{m_a[31]}}, m_a} : {32'h0, m_a};
        sbv = (m_op == 2'd1) ? {{32{m_b[31]}}, m_b} : {32'h0, m_b};
        return sa * sbv;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with result %h, required no done", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(result), 64'(e.res));
                check({e.name, "_product"}, product, e.prod);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] r, input logic [63:0] p);
        exp_t e;
        e.name = nm;
        e.res  = r;
        e.prod = p;
        sb.push_back(e);
    endtask

    // Called #1 after the start edge; returns edges from start to done and busy cycles seen
    task automatic wait_done(input string nm, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required done", nm, lat);
        end
    endtask

    task automatic drive_start(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
        @(negedge clk);
        op    = t_op;
        a     = t_a;
        b     = t_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [1:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input logic [31:0] r, input logic [63:0] p);
        int lat, bc, exp_lat;
        exp_lat = (t_a == 0 || t_b == 0) ? 1 : 33;
        push_exp(nm, r, p);
        drive_start(t_op, t_a, t_b);
        wait_done(nm, lat, bc);
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_busy_cycles"}, 64'(bc), (exp_lat == 1) ? 64'd0 : 64'd32);
    endtask

    initial begin
        int          lat, bc;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        logic [63:0] p;

        vecs[0] = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002A, 64'h000000000000002A};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000001};
        vecs[2] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 64'h4000000000000000};
        vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001};
        vecs[4] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001};
        vecs[5] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 64'h00000004FFFFFFF1};
        vecs[6] = '{2'b00, 32'h00000000, 32'd123,      32'h00000000, 64'h0000000000000000};
        vecs[7] = '{2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFF00000000};
        vecs[8] = '{2'b01, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF6};
        vecs[9] = '{2'b11, 32'h12345678, 32'h00000000, 32'h00000000, 64'h0000000000000000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].prod);
        end

        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i == 2) ? 32'h0 : $urandom;
            p    = model(r_op, r_a, r_b);
            run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, (r_op == 2'b00) ? p[31:0] : p[63:32], p);
        end

        // Start while busy is ignored; the first operation's 42 comes back
        push_exp("ignore_start", 32'h2A, 64'h2A);
        drive_start(2'b00, 32'd7, 32'd6);
        repeat (4) @(posedge clk);
        drive_start(2'b11, 32'd100, 32'd100);
        wait_done("ignore_start", lat, bc);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back: second start lands in the DONE cycle, CALC follows with no IDLE gap
        run_op("b2b_first", 2'b00, 32'd3, 32'd4, 32'd12, 64'd12);
        op    = 2'b11;
        a     = 32'hFFFFFFFF;
        b     = 32'd3;
        start = 1'b1;
        push_exp("b2b_second", 32'h2, 64'h00000002FFFFFFFD);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_no_gap_busy", 64'(busy), 64'd1);
        wait_done("b2b_second", lat, bc);
        check("b2b_second_latency", 64'(lat), 64'd33);
        repeat (2) @(posedge clk);

        // Abort at t10: back to IDLE, no done, outputs keep the previous product
        drive_start(2'b00, 32'd9, 32'd9);
        repeat (8) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product_hold", product, 64'h00000002FFFFFFFD);
        check("abort_result_hold", 64'(result), 64'h2);
        repeat (40) @(posedge clk);

        // abort while idle has no effect: start in the same cycle is accepted
        push_exp("abort_idle", 32'h2A, 64'h2A);
        @(negedge clk);
        op    = 2'b00;
        a     = 32'd7;
        b     = 32'd6;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        wait_done("abort_idle", lat, bc);
        check("abort_idle_latency", 64'(lat), 64'd33);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_in_done_product", product, 64'h2A);

        // Synchronous reset mid-operation clears everything, next operation completes normally
        drive_start(2'b00, 32'h1234, 32'h5678);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        abort = 1'b0;
        p = model(2'b00, 32'h1234, 32'h5678);
        run_op("after_rst", 2'b00, 32'h1234, 32'h5678, p[31:0], p);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
